pe_mac_sequencer: RTL and testbench
===================================

Name: pe_mac_sequencer

Overview:
- Sequences one PE through a multiply-accumulate over a vector of operand pairs. Each result is fed back as the PE addend `p`; the final accumulator is returned to the requester.
- Sits between a command/operand source (DMA or the array controller) and a single PE instance.
- Configures the PE mode: full 64-bit MAC, or dual-lane 32-bit MAC.
- The PE is treated as a result path with fixed latency; this block owns all registers around it.

Parameters:
- LEN_W, 16, width of the element-count field; maximum vector length is 2^LEN_W-1.
- PE_LAT, 1, cycles from driving PE inputs to sampling `pe_y`; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous reset, active low.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when both valid and ready are high.
- cmd_len  in  LEN_W  number of operand pairs.
- cmd_mode  in  1  0 = 64-bit MAC, 1 = dual 32-bit lanes.
- cmd_init  in  64  initial accumulator value.
- op_valid  in  1  operand pair valid.
- op_ready  out  1  operand pair accepted when both valid and ready are high.
- op_a  in  64  operand a.
- op_b  in  64  operand b.
- pe_a  out  64  PE operand a (registered).
- pe_b  out  64  PE operand b (registered).
- pe_p  out  64  PE addend; always equals the accumulator.
- pe_control  out  4  PE mode: 4'b0000 for mode 0, 4'b0001 for mode 1.
- pe_y  in  64  PE result.
- res_valid  out  1  result valid.
- res_ready  in  1  result consumed when both valid and ready are high.
- res_data  out  64  final accumulator.
- res_count  out  LEN_W  number of pairs processed.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- States: IDLE, LOAD, WAIT, DONE. All outputs are registered.
- Reset (async assert, sync deassert by the integrator):
  - state = IDLE.
  - cmd_ready = 1, op_ready = 0, res_valid = 0, busy = 0.
  - pe_a, pe_b, pe_p, res_data = 0; pe_control = 0; res_count = 0.
  - All internal counters = 0.
- IDLE:
  - cmd_ready = 1.
  - On command handshake: latch len and mode; acc <= cmd_init; elem counter <= 0; cmd_ready <= 0.
  - If cmd_len == 0: go to DONE with res_data = cmd_init and res_count = 0.
  - Otherwise go to LOAD.
- LOAD:
  - op_ready = 1.
  - On operand handshake: pe_a <= op_a; pe_b <= op_b; lat counter <= 0; op_ready <= 0; go to WAIT.
  - Without a handshake: remain in LOAD, outputs held.
- WAIT:
  - lat counter increments each cycle.
  - In the cycle where lat counter == PE_LAT-1: acc <= pe_y and elem counter += 1.
  - If the new count == len: go to DONE. Otherwise go back to LOAD.
  - pe_a, pe_b, pe_p and pe_control are stable for the whole of WAIT.
- DONE:
  - res_valid = 1; res_data = acc; res_count = elem counter. These are held stable until res_ready.
  - On result handshake: res_valid <= 0; cmd_ready <= 1; go to IDLE.
  - No new command is accepted while in DONE; there is no overlap between commands.
- Throughput:
  - Per element: 1 cycle in LOAD plus PE_LAT cycles in WAIT, assuming op_valid is already high.
  - Result becomes valid 1 cycle after the final capture.
- Mode:
  - pe_control is a function of the latched mode only; it does not change mid-command.
  - This block performs no lane arithmetic; the lane split is entirely inside the PE.
- Counters:
  - elem counter is LEN_W bits and cannot wrap, because len ≤ 2^LEN_W-1.
  - lat counter is 4 bits.
- Boundaries:
  - op_valid while not in LOAD is ignored.
  - cmd_valid outside IDLE is ignored.
  - res_ready without res_valid has no effect.
  - Reset asserted mid-command aborts immediately: partial accumulator discarded, no result emitted.

Test Plan:
(Bench PE model: pe_y = pe_a*pe_b + pe_p, low 64 bits, sampled PE_LAT cycles after inputs.)
- PE_LAT=1, cmd_len=3, init=5, pairs (2,3),(4,5),(1,7) → res_data = 38, res_count = 3, pe_control = 0; res_valid rises 7 cycles after the command handshake, with op_valid held high throughout.
- cmd_len=0, init=0xDEAD → DONE one cycle after the command; res_data = 0xDEAD, res_count = 0; op_ready never asserts.
- cmd_mode=1, cmd_len=2 → pe_control = 4'b0001 in every LOAD and WAIT cycle; returns to IDLE after res_ready.
- PE_LAT=3, op_valid gapped by 4 idle cycles per pair, res_ready held low for 5 cycles → op_ready stays high across each gap; res_data stable while stalled; exactly 2 captures occur.
- rst_n pulsed low in WAIT of element 2 of 4 → all outputs return to reset values asynchronously; a following cmd_len=1, init=0, pair (6,7) returns 42.
- cmd_valid held high during DONE → cmd_ready stays 0; the second command is accepted only in the IDLE cycle after the result handshake.

Source files
------------

// File: rtl/pe_mac_sequencer.sv
// Purpose : walks one PE through a MAC over a vector of operand pairs, feeding each result back as the addend.
// Latency : 1 LOAD cycle + PE_LAT WAIT cycles per pair; res_valid rises 1 cycle after the final capture.
// Backpr. : op_ready only in LOAD; res_data/res_count held until res_ready; no new command until the result is taken.
//
// Ports:
//   clk, rst_n                    clock (rising edge), asynchronous active-low reset
//   cmd_valid/ready, cmd_len,     command: pair count, mode (0 = 64-bit MAC, 1 = dual 32-bit lanes),
//     cmd_mode, cmd_init            initial accumulator value
//   op_valid/ready, op_a, op_b    operand pair stream
//   pe_a, pe_b, pe_p, pe_control  registered PE drive; pe_p is the accumulator
//   pe_y                          PE result, sampled PE_LAT cycles after the PE inputs change
//   res_valid/ready, res_data,    final accumulator and number of pairs processed
//     res_count
//   busy                          high whenever the sequencer is not idle
module pe_mac_sequencer #(
   parameter int LEN_W  = 16,
   parameter int PE_LAT = 1     // legal range 1..15
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [LEN_W-1:0] cmd_len,
   input  logic             cmd_mode,
   input  logic [63:0]      cmd_init,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic [63:0]      op_a,
   input  logic [63:0]      op_b,
   output logic [63:0]      pe_a,
   output logic [63:0]      pe_b,
   output logic [63:0]      pe_p,
   output logic [3:0]       pe_control,
   input  logic [63:0]      pe_y,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [63:0]      res_data,
   output logic [LEN_W-1:0] res_count,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, LOAD, WAIT, DONE} state_t;

   localparam logic [3:0] LAT_LAST = 4'(PE_LAT - 1);

   state_t           state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] elem_q, elem_d, elem_inc;
   logic [3:0]       lat_q, lat_d;
   logic [63:0]      acc_q, acc_d;
   logic [63:0]      pe_a_d, pe_b_d, res_data_d;
   logic [3:0]       pe_control_d;
   logic [LEN_W-1:0] res_count_d;
   logic             cmd_ready_d, op_ready_d, res_valid_d, busy_d;

   logic cmd_hs, op_hs, res_hs, lat_done;

   assign cmd_hs   = cmd_valid & cmd_ready;
   assign op_hs    = op_valid & op_ready;
   assign res_hs   = res_valid & res_ready;
   assign lat_done = (state_q == WAIT) && (lat_q == LAT_LAST);
   assign elem_inc = elem_q + LEN_W'(1);

   // The PE addend is the accumulator register itself.
   assign pe_p = acc_q;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (cmd_hs) state_d = (cmd_len == '0) ? DONE : LOAD;
         LOAD: if (op_hs)  state_d = WAIT;
         WAIT: if (lat_done) state_d = (elem_inc == len_q) ? DONE : LOAD;
         DONE: if (res_hs) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output logic: next values of every registered output and counter
   always_comb begin
      cmd_ready_d  = cmd_ready;
      op_ready_d   = op_ready;
      res_valid_d  = res_valid;
      pe_a_d       = pe_a;
      pe_b_d       = pe_b;
      pe_control_d = pe_control;
      res_data_d   = res_data;
      res_count_d  = res_count;
      acc_d        = acc_q;
      len_d        = len_q;
      elem_d       = elem_q;
      lat_d        = lat_q;
      busy_d       = (state_d != IDLE);
      case (state_q)
         IDLE: begin
            if (cmd_hs) begin
               len_d        = cmd_len;
               pe_control_d = {3'b000, cmd_mode};
               acc_d        = cmd_init;
               elem_d       = '0;
               cmd_ready_d  = 1'b0;
               op_ready_d   = (cmd_len != '0);
            end
         end
         LOAD: begin
            if (op_hs) begin
               pe_a_d     = op_a;
               pe_b_d     = op_b;
               lat_d      = '0;
               op_ready_d = 1'b0;
            end
         end
         WAIT: begin
            lat_d = lat_q + 4'd1;
            if (lat_done) begin
               acc_d      = pe_y;
               elem_d     = elem_inc;
               op_ready_d = (elem_inc != len_q);
            end
         end
         DONE: begin
            // First DONE cycle publishes the result; it is then frozen until taken.
            if (!res_valid) begin
               res_valid_d = 1'b1;
               res_data_d  = acc_q;
               res_count_d = elem_q;
            end else if (res_ready) begin
               res_valid_d = 1'b0;
               cmd_ready_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_ready  <= 1'b1;
         op_ready   <= 1'b0;
         res_valid  <= 1'b0;
         busy       <= 1'b0;
         pe_a       <= '0;
         pe_b       <= '0;
         pe_control <= '0;
         res_data   <= '0;
         res_count  <= '0;
         acc_q      <= '0;
         len_q      <= '0;
         elem_q     <= '0;
         lat_q      <= '0;
      end else begin
         cmd_ready  <= cmd_ready_d;
         op_ready   <= op_ready_d;
         res_valid  <= res_valid_d;
         busy       <= busy_d;
         pe_a       <= pe_a_d;
         pe_b       <= pe_b_d;
         pe_control <= pe_control_d;
         res_data   <= res_data_d;
         res_count  <= res_count_d;
         acc_q      <= acc_d;
         len_q      <= len_d;
         elem_q     <= elem_d;
         lat_q      <= lat_d;
      end
   end

endmodule

// File: tb/tb_pe_mac_sequencer.sv
// Purpose : exercises two sequencers (PE_LAT=1 and PE_LAT=3) against a PE model and a MAC reference.
// Latency : PE model returns a*b+p, low 64 bits, PE_LAT cycles after its inputs change.
// Backpr. : bench drives gapped operands and stalled result acceptance.
module tb_pe_mac_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid [2];
   logic        cmd_ready [2];
   logic [15:0] cmd_len   [2];
   logic        cmd_mode  [2];
   logic [63:0] cmd_init  [2];
   logic        op_valid  [2];
   logic        op_ready  [2];
   logic [63:0] op_a      [2];
   logic [63:0] op_b      [2];
   logic [63:0] pe_a      [2];
   logic [63:0] pe_b      [2];
   logic [63:0] pe_p      [2];
   logic [3:0]  pe_control[2];
   logic [63:0] pe_y      [2];
   logic        res_valid [2];
   logic        res_ready [2];
   logic [63:0] res_data  [2];
   logic [15:0] res_count [2];
   logic        busy      [2];

   int total = 0;
   int bad   = 0;
   int ophs[2] = '{0, 0};
   logic [63:0] av[16];
   logic [63:0] bv[16];
   logic [63:0] d1, d2;

   always #5 clk = ~clk;

   // PE models: instance 0 is single-cycle, instance 1 has two extra pipeline stages.
   assign pe_y[0] = pe_a[0] * pe_b[0] + pe_p[0];
   always @(posedge clk) begin
      d1 <= pe_a[1] * pe_b[1] + pe_p[1];
      d2 <= d1;
   end
   assign pe_y[1] = d2;

   always @(posedge clk) begin
      for (int w = 0; w < 2; w++)
         if (op_valid[w] && op_ready[w]) ophs[w]++;
   end

   pe_mac_sequencer #(.LEN_W(16), .PE_LAT(1)) u_dut_l1 (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_len(cmd_len[0]),
      .cmd_mode(cmd_mode[0]), .cmd_init(cmd_init[0]),
      .op_valid(op_valid[0]), .op_ready(op_ready[0]), .op_a(op_a[0]), .op_b(op_b[0]),
      .pe_a(pe_a[0]), .pe_b(pe_b[0]), .pe_p(pe_p[0]), .pe_control(pe_control[0]), .pe_y(pe_y[0]),
      .res_valid(res_valid[0]), .res_ready(res_ready[0]), .res_data(res_data[0]),
      .res_count(res_count[0]), .busy(busy[0])
   );

   pe_mac_sequencer #(.LEN_W(16), .PE_LAT(3)) u_dut_l3 (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_len(cmd_len[1]),
      .cmd_mode(cmd_mode[1]), .cmd_init(cmd_init[1]),
      .op_valid(op_valid[1]), .op_ready(op_ready[1]), .op_a(op_a[1]), .op_b(op_b[1]),
      .pe_a(pe_a[1]), .pe_b(pe_b[1]), .pe_p(pe_p[1]), .pe_control(pe_control[1]), .pe_y(pe_y[1]),
      .res_valid(res_valid[1]), .res_ready(res_ready[1]), .res_data(res_data[1]),
      .res_count(res_count[1]), .busy(busy[1])
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   // Reference: init + sum of a_i*b_i, modulo 2^64.
   function automatic logic [63:0] ref_mac(input logic [63:0] init, input int n);
      logic [63:0] acc = init;
      for (int i = 0; i < n; i++) acc = acc + av[i] * bv[i];
      return acc;
   endfunction

   // Runs one full command on instance w and reports what was observed.
   task automatic drive_cmd(input int w, input int len, input bit mode, input logic [63:0] init,
                            input int gap, input int stall,
                            output int lat_cyc, output logic [63:0] r_data, output logic [15:0] r_cnt,
                            output bit ctrl_ok, output bit op_seen, output bit drop_ok,
                            output bit hold_ok, output bit done_ok, output bit tmo, output int caps);
      int n, idx, gc, cyc, base;
      bit hs, prev_rdy, prev_hs;
      ctrl_ok = 1; op_seen = 0; drop_ok = 1; hold_ok = 1; done_ok = 1; tmo = 0;
      lat_cyc = 0; r_data = '0; r_cnt = '0; caps = 0;
      cmd_len[w] = 16'(len); cmd_mode[w] = mode; cmd_init[w] = init; cmd_valid[w] = 1'b1;
      n = 0;
      while (!cmd_ready[w] && n < 50) begin tick(); n++; end
      if (!cmd_ready[w]) begin tmo = 1; cmd_valid[w] = 1'b0; return; end
      idx = 0; gc = 0;
      if (gap == 0) begin op_valid[w] = 1'b1; op_a[w] = av[0]; op_b[w] = bv[0]; end
      else op_valid[w] = 1'b0;
      base = ophs[w];
      tick();
      cmd_valid[w] = 1'b0;
      cyc = 0; prev_rdy = 0; prev_hs = 0;
      while (!res_valid[w] && cyc < 1000) begin
         if (busy[w] && pe_control[w] !== {3'b000, mode}) ctrl_ok = 0;
         if (op_ready[w]) op_seen = 1;
         if (prev_rdy && !prev_hs && !op_ready[w]) drop_ok = 0;
         hs = op_valid[w] && op_ready[w];
         prev_rdy = op_ready[w]; prev_hs = hs;
         tick(); cyc++;
         if (hs) begin
            idx++; gc = 0;
            if (gap > 0) op_valid[w] = 1'b0;
            else begin
               op_a[w] = (idx < len) ? av[idx] : rnd64();
               op_b[w] = (idx < len) ? bv[idx] : rnd64();
            end
         end else if (!op_valid[w]) begin
            gc++;
            if (gc >= gap) begin
               op_valid[w] = 1'b1;
               op_a[w] = (idx < len) ? av[idx] : rnd64();
               op_b[w] = (idx < len) ? bv[idx] : rnd64();
            end
         end
      end
      op_valid[w] = 1'b0;
      if (!res_valid[w]) begin tmo = 1; return; end
      lat_cyc = cyc; r_data = res_data[w]; r_cnt = res_count[w]; caps = ophs[w] - base;
      res_ready[w] = 1'b0;
      for (int i = 0; i < stall; i++) begin
         tick();
         if (res_valid[w] !== 1'b1 || res_data[w] !== r_data || res_count[w] !== r_cnt ||
             cmd_ready[w] !== 1'b0) hold_ok = 0;
      end
      res_ready[w] = 1'b1;
      tick();
      res_ready[w] = 1'b0;
      if (res_valid[w] !== 1'b0 || cmd_ready[w] !== 1'b1 || busy[w] !== 1'b0) done_ok = 0;
   endtask

   task automatic test_reset();
      for (int w = 0; w < 2; w++) begin
         total++; if (cmd_ready[w] !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready[%0d] got=%b exp=1", w, cmd_ready[w]); end
         total++; if (op_ready[w] !== 1'b0) begin bad++; $display("FAIL reset_op_ready[%0d] got=%b exp=0", w, op_ready[w]); end
         total++; if (res_valid[w] !== 1'b0) begin bad++; $display("FAIL reset_res_valid[%0d] got=%b exp=0", w, res_valid[w]); end
         total++; if (busy[w] !== 1'b0) begin bad++; $display("FAIL reset_busy[%0d] got=%b exp=0", w, busy[w]); end
         total++; if (pe_a[w] !== 64'd0 || pe_b[w] !== 64'd0 || pe_p[w] !== 64'd0)
            begin bad++; $display("FAIL reset_pe_ops[%0d] got=%h/%h/%h exp=0", w, pe_a[w], pe_b[w], pe_p[w]); end
         total++; if (pe_control[w] !== 4'd0) begin bad++; $display("FAIL reset_pe_control[%0d] got=%h exp=0", w, pe_control[w]); end
         total++; if (res_data[w] !== 64'd0 || res_count[w] !== 16'd0)
            begin bad++; $display("FAIL reset_res[%0d] got=%h/%0d exp=0/0", w, res_data[w], res_count[w]); end
      end
   endtask

   task automatic test_basic();
      int lat, caps; logic [63:0] rd; logic [15:0] rc; bit c_ok, seen, d_ok, h_ok, dn_ok, tmo;
      av[0] = 64'd2; bv[0] = 64'd3; av[1] = 64'd4; bv[1] = 64'd5; av[2] = 64'd1; bv[2] = 64'd7;
      drive_cmd(0, 3, 1'b0, 64'd5, 0, 2, lat, rd, rc, c_ok, seen, d_ok, h_ok, dn_ok, tmo, caps);
      total++; if (tmo) begin bad++; $display("FAIL basic_timeout got=1 exp=0"); end
      total++; if (rd !== 64'd38) begin bad++; $display("FAIL basic_res_data got=%0d exp=38", rd); end
      total++; if (rc !== 16'd3) begin bad++; $display("FAIL basic_res_count got=%0d exp=3", rc); end
      total++; if (lat !== 7) begin bad++; $display("FAIL basic_latency got=%0d exp=7", lat); end
      total++; if (!c_ok) begin bad++; $display("FAIL basic_pe_control got=bad exp=0000"); end
      total++; if (caps !== 3) begin bad++; $display("FAIL basic_captures got=%0d exp=3", caps); end
      total++; if (!h_ok || !dn_ok) begin bad++; $display("FAIL basic_result_hs got=%b%b exp=11", h_ok, dn_ok); end
   endtask

   task automatic test_len_zero();
      int lat, caps; logic [63:0] rd; logic [15:0] rc; bit c_ok, seen, d_ok, h_ok, dn_ok, tmo;
      drive_cmd(0, 0, 1'b0, 64'hDEAD, 0, 1, lat, rd, rc, c_ok, seen, d_ok, h_ok, dn_ok, tmo, caps);
      total++; if (tmo) begin bad++; $display("FAIL zero_timeout got=1 exp=0"); end
      total++; if (rd !== 64'hDEAD) begin bad++; $display("FAIL zero_res_data got=%h exp=dead", rd); end
      total++; if (rc !== 16'd0) begin bad++; $display("FAIL zero_res_count got=%0d exp=0", rc); end
      total++; if (lat !== 1) begin bad++; $display("FAIL zero_latency got=%0d exp=1", lat); end
      total++; if (seen) begin bad++; $display("FAIL zero_op_ready got=1 exp=never"); end
      total++; if (!dn_ok) begin bad++; $display("FAIL zero_return_idle got=0 exp=1"); end
   endtask

   task automatic test_mode();
      int lat, caps; logic [63:0] rd, exp_d; logic [15:0] rc; bit c_ok, seen, d_ok, h_ok, dn_ok, tmo;
      for (int i = 0; i < 2; i++) begin av[i] = rnd64(); bv[i] = rnd64(); end
      exp_d = rnd64();
      drive_cmd(0, 2, 1'b1, exp_d, 0, 0, lat, rd, rc, c_ok, seen, d_ok, h_ok, dn_ok, tmo, caps);
      exp_d = ref_mac(exp_d, 2);
      total++; if (tmo) begin bad++; $display("FAIL mode_timeout got=1 exp=0"); end
      total++; if (!c_ok) begin bad++; $display("FAIL mode_pe_control got=bad exp=0001"); end
      total++; if (rd !== exp_d) begin bad++; $display("FAIL mode_res_data got=%h exp=%h", rd, exp_d); end
      total++; if (!dn_ok) begin bad++; $display("FAIL mode_return_idle got=0 exp=1"); end
   endtask

   task automatic test_gap_stall();
      int lat, caps; logic [63:0] rd, init, exp_d; logic [15:0] rc; bit c_ok, seen, d_ok, h_ok, dn_ok, tmo;
      for (int i = 0; i < 2; i++) begin av[i] = rnd64(); bv[i] = rnd64(); end
      init = rnd64();
      drive_cmd(1, 2, 1'b0, init, 4, 5, lat, rd, rc, c_ok, seen, d_ok, h_ok, dn_ok, tmo, caps);
      exp_d = ref_mac(init, 2);
      total++; if (tmo) begin bad++; $display("FAIL gap_timeout got=1 exp=0"); end
      total++; if (!d_ok) begin bad++; $display("FAIL gap_op_ready_drop got=dropped exp=held"); end
      total++; if (!h_ok) begin bad++; $display("FAIL gap_result_stall got=changed exp=stable"); end
      total++; if (caps !== 2) begin bad++; $display("FAIL gap_captures got=%0d exp=2", caps); end
      total++; if (rd !== exp_d || rc !== 16'd2)
         begin bad++; $display("FAIL gap_result got=%h/%0d exp=%h/2", rd, rc, exp_d); end
   endtask

   task automatic test_reset_mid();
      int n, idx, lat, caps; bit hs; logic [63:0] rd; logic [15:0] rc; bit c_ok, seen, d_ok, h_ok, dn_ok, tmo;
      for (int i = 0; i < 4; i++) begin av[i] = rnd64(); bv[i] = rnd64(); end
      cmd_len[1] = 16'd4; cmd_mode[1] = 1'b1; cmd_init[1] = rnd64(); cmd_valid[1] = 1'b1;
      op_valid[1] = 1'b1; op_a[1] = av[0]; op_b[1] = bv[0];
      tick();
      cmd_valid[1] = 1'b0;
      idx = 0; n = 0;
      while (idx < 2 && n < 100) begin
         hs = op_valid[1] && op_ready[1];
         tick(); n++;
         if (hs) begin idx++; op_a[1] = av[idx]; op_b[1] = bv[idx]; end
      end
      total++; if (idx < 2) begin bad++; $display("FAIL rstmid_timeout got=%0d exp=2", idx); end
      tick();
      total++; if (busy[1] !== 1'b1 || pe_a[1] !== av[1])
         begin bad++; $display("FAIL rstmid_in_wait got=%b/%h exp=1/%h", busy[1], pe_a[1], av[1]); end
      op_valid[1] = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      total++; if (busy[1] !== 1'b0 || cmd_ready[1] !== 1'b1 || op_ready[1] !== 1'b0 || res_valid[1] !== 1'b0)
         begin bad++; $display("FAIL rstmid_ctrl got=%b%b%b%b exp=0100", busy[1], cmd_ready[1], op_ready[1], res_valid[1]); end
      total++; if (pe_a[1] !== 64'd0 || pe_b[1] !== 64'd0 || pe_p[1] !== 64'd0 || pe_control[1] !== 4'd0)
         begin bad++; $display("FAIL rstmid_pe got=%h/%h/%h/%h exp=0", pe_a[1], pe_b[1], pe_p[1], pe_control[1]); end
      #1 rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         total++; if (res_valid[1] !== 1'b0 || busy[1] !== 1'b0)
            begin bad++; $display("FAIL rstmid_no_result got=%b/%b exp=0/0", res_valid[1], busy[1]); end
      end
      av[0] = 64'd6; bv[0] = 64'd7;
      drive_cmd(1, 1, 1'b0, 64'd0, 0, 0, lat, rd, rc, c_ok, seen, d_ok, h_ok, dn_ok, tmo, caps);
      total++; if (tmo || rd !== 64'd42 || rc !== 16'd1)
         begin bad++; $display("FAIL rstmid_after got=%0d/%0d tmo=%b exp=42/1", rd, rc, tmo); end
   endtask

   task automatic test_back_to_back();
      int n; logic [63:0] init, x, exp_d;
      av[0] = rnd64(); bv[0] = rnd64(); init = rnd64(); x = rnd64();
      exp_d = ref_mac(init, 1);
      cmd_len[0] = 16'd1; cmd_mode[0] = 1'b0; cmd_init[0] = init; cmd_valid[0] = 1'b1;
      op_valid[0] = 1'b1; op_a[0] = av[0]; op_b[0] = bv[0];
      tick();
      cmd_valid[0] = 1'b0;
      n = 0;
      while (!res_valid[0] && n < 100) begin tick(); n++; end
      op_valid[0] = 1'b0;
      total++; if (res_valid[0] !== 1'b1 || res_data[0] !== exp_d)
         begin bad++; $display("FAIL b2b_first got=%b/%h exp=1/%h", res_valid[0], res_data[0], exp_d); end
      cmd_len[0] = 16'd0; cmd_init[0] = x; cmd_valid[0] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if (cmd_ready[0] !== 1'b0 || res_valid[0] !== 1'b1)
            begin bad++; $display("FAIL b2b_cmd_ready_in_done got=%b/%b exp=0/1", cmd_ready[0], res_valid[0]); end
      end
      res_ready[0] = 1'b1;
      tick();
      res_ready[0] = 1'b0;
      total++; if (cmd_ready[0] !== 1'b1 || busy[0] !== 1'b0)
         begin bad++; $display("FAIL b2b_idle_cycle got=%b/%b exp=1/0", cmd_ready[0], busy[0]); end
      tick();
      cmd_valid[0] = 1'b0;
      total++; if (cmd_ready[0] !== 1'b0 || busy[0] !== 1'b1)
         begin bad++; $display("FAIL b2b_accept got=%b/%b exp=0/1", cmd_ready[0], busy[0]); end
      n = 0;
      while (!res_valid[0] && n < 100) begin tick(); n++; end
      total++; if (res_valid[0] !== 1'b1 || res_data[0] !== x || res_count[0] !== 16'd0)
         begin bad++; $display("FAIL b2b_second got=%b/%h/%0d exp=1/%h/0", res_valid[0], res_data[0], res_count[0], x); end
      res_ready[0] = 1'b1;
      tick();
      res_ready[0] = 1'b0;
   endtask

   task automatic test_random();
      int w, len, gap, stall, lat, caps, exp_lat; bit mode;
      logic [63:0] rd, init, exp_d; logic [15:0] rc; bit c_ok, seen, d_ok, h_ok, dn_ok, tmo;
      for (int it = 0; it < 12; it++) begin
         w = int'($urandom_range(0, 1)); len = int'($urandom_range(0, 6));
         gap = int'($urandom_range(0, 2)); stall = int'($urandom_range(0, 3));
         mode = 1'($urandom_range(0, 1)); init = rnd64();
         for (int i = 0; i < len; i++) begin av[i] = rnd64(); bv[i] = rnd64(); end
         drive_cmd(w, len, mode, init, gap, stall, lat, rd, rc, c_ok, seen, d_ok, h_ok, dn_ok, tmo, caps);
         exp_d = ref_mac(init, len);
         exp_lat = len * (1 + ((w == 1) ? 3 : 1)) + 1;
         total++; if (tmo) begin bad++; $display("FAIL rnd%0d_timeout got=1 exp=0", it); end
         total++; if (rd !== exp_d || rc !== 16'(len))
            begin bad++; $display("FAIL rnd%0d_result got=%h/%0d exp=%h/%0d", it, rd, rc, exp_d, len); end
         total++; if (caps !== len) begin bad++; $display("FAIL rnd%0d_captures got=%0d exp=%0d", it, caps, len); end
         total++; if (!c_ok || !d_ok || !h_ok || !dn_ok)
            begin bad++; $display("FAIL rnd%0d_flow got=%b%b%b%b exp=1111", it, c_ok, d_ok, h_ok, dn_ok); end
         if (gap == 0) begin
            total++; if (lat !== exp_lat) begin bad++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", it, lat, exp_lat); end
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      for (int w = 0; w < 2; w++) begin
         cmd_valid[w] = 1'b0; cmd_len[w] = '0; cmd_mode[w] = 1'b0; cmd_init[w] = '0;
         op_valid[w] = 1'b0; op_a[w] = '0; op_b[w] = '0; res_ready[w] = 1'b0;
      end
      tick(); tick();
      rst_n = 1'b1;
      tick();
      test_reset();
      test_basic();
      test_len_zero();
      test_mode();
      test_gap_stall();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
